shift_rgst_seq: RTL and testbench
=================================

Name: shift_rgst_seq

Overview:
- Parametrised sequential shift register for the ALU datapath, for divider/multiplier normalisation.
- Performs a multi-position shift (left/right; logical, arithmetic, rotate, serial-fill) one bit per clock.
- Uses a start/busy/done handshake and a parallel load path.
- Replaces the single-step load/shift register in blocks that need shifts by a run-time amount.

Parameters:
- WIDTH, 8, data register width (>= 2).
- SHAMT_W, 4, width of the shift-amount input (amounts 0 .. 2^SHAMT_W-1).

Ports:
- clk  input  1  system clock, all state on rising edge.
- reset  input  1  synchronous, active-low reset.
- load_enable  input  1  parallel load of data_in (IDLE only).
- data_in  input  WIDTH  parallel load value.
- start  input  1  begin shift operation (IDLE only).
- dir  input  1  0 = left, 1 = right; sampled at start.
- mode  input  2  00 logical, 01 arithmetic, 10 rotate, 11 serial-fill; sampled at start.
- serial_in  input  1  fill bit for mode 11; sampled every SHIFT cycle.
- shamt  input  SHAMT_W  number of single-bit steps; sampled at start.
- data_out  output  WIDTH  register contents.
- shift_out  output  1  bit shifted out on the most recent step; held between operations.
- busy  output  1  high in SHIFT and DONE states.
- done  output  1  one-cycle pulse in DONE state.
- sticky  output  1  only with RGST_STICKY_EN; see Optional Feature.

Behaviour:
- Reset (reset == 0 at a clock edge): state IDLE, data_out = 0, shift_out = 0, busy = 0, done = 0, step counter = 0, sticky = 0. Reset overrides everything, including mid-operation; the operation is abandoned with no done pulse.
- FSM states: IDLE, SHIFT, DONE.
- IDLE priority:
  - load_enable: data_out <= data_in; stay in IDLE.
  - else start with shamt != 0: latch dir/mode, counter <= shamt, go to SHIFT.
  - else start with shamt == 0: go to DONE; data_out and shift_out unchanged.
  - load_enable and start together: load wins, start is dropped.
- SHIFT: each cycle performs one step and decrements the counter. When the counter is 1, perform the step and go to DONE.
- DONE: done = 1 for exactly one cycle, then IDLE.
- Latency: with start accepted at edge T, data_out holds the final result after edge T+shamt. done is high in the cycle after that edge (DONE state), and busy drops one edge later.
- load_enable and start are ignored while busy = 1; inputs other than serial_in are not sampled during SHIFT.
- Step definitions, left (dir = 0):
  - shift_out <= bit[W-1].
  - Fill bit[0]: logical/arithmetic -> 0; rotate -> old bit[W-1]; serial-fill -> serial_in.
- Step definitions, right (dir = 1):
  - shift_out <= bit[0].
  - Fill bit[W-1]: logical -> 0; arithmetic -> old bit[W-1]; rotate -> old bit[0]; serial-fill -> serial_in.
- shamt > WIDTH is legal: performs shamt real steps, no clamping. Logical ends at 0, arithmetic saturates to all sign bits, rotate wraps modulo WIDTH with full cycle cost.
- Counter is SHAMT_W bits; no wrap, since decrement stops at 1.

Optional Feature:
- Macro RGST_STICKY_EN.
- Defined:
  - Adds output sticky.
  - Cleared on accepted start and on load.
  - In SHIFT, sticky <= sticky | (bit shifted out), for the guard/sticky logic of rounding and division remainder checks.
  - Held after DONE until the next start/load/reset.
- Undefined: no sticky port, no associated register; all other behaviour identical.

Test Plan (WIDTH = 8, SHAMT_W = 4):
- Load 0xB4; start dir=0, mode=00, shamt=3 -> busy for 4 cycles; done pulse on 4th cycle after start; data_out = 0xA0; shift_out = 1.
- Load 0xB4; start dir=1, mode=01, shamt=2 -> data_out = 0xED, shift_out = 0, done after 2 SHIFT cycles.
- Load 0x81; start dir=1, mode=10, shamt=9 -> 9 SHIFT cycles; data_out = 0xC0; shift_out = 1.
- Load 0x00; start dir=0, mode=11, shamt=4, serial_in = 1,0,1,1 per cycle -> data_out = 0x0B. Then start with shamt=0 -> done the next cycle, data_out still 0x0B.
- Mid-operation interference:
  - Load 0xFF; start dir=1, mode=00, shamt=6; assert load_enable with data_in=0x12 on cycle 2 -> ignored, final data_out = 0x03.
  - Repeat, pulling reset low on cycle 3 -> data_out = 0, IDLE, no done pulse.
- RGST_STICKY_EN defined: load 0x05; start dir=1, mode=00, shamt=3 -> data_out = 0x00, shift_out = 1, sticky = 1. Load 0x08 and repeat -> sticky = 0, data_out = 0x01.

Source files
------------

// File: rtl/shift_rgst_seq_if.sv
// Handshake/data bundle for shift_rgst_seq; RGST_STICKY_EN adds the sticky output.
interface shift_rgst_seq_if #(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned SHAMT_W = 4
);
    logic               load_enable;
    logic [WIDTH-1:0]   data_in;
    logic               start;
    logic               dir;
    logic [1:0]         mode;
    logic               serial_in;
    logic [SHAMT_W-1:0] shamt;
    logic [WIDTH-1:0]   data_out;
    logic               shift_out;
    logic               busy;
    logic               done;
`ifdef RGST_STICKY_EN
    logic               sticky;
`endif

    modport master (
        output load_enable, data_in, start, dir, mode, serial_in, shamt,
`ifdef RGST_STICKY_EN
        input  sticky,
`endif
        input  data_out, shift_out, busy, done
    );

    modport slave (
        input  load_enable, data_in, start, dir, mode, serial_in, shamt,
`ifdef RGST_STICKY_EN
        output sticky,
`endif
        output data_out, shift_out, busy, done
    );
endinterface

// File: rtl/shift_rgst_seq.sv
// Multi-step shift register: one bit per clock, start/busy/done handshake, parallel load.
// Optional sticky-bit accumulation enabled by defining RGST_STICKY_EN.
module shift_rgst_seq #(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned SHAMT_W = 4
) (
    input logic             clk_i,
    input logic             reset_ni,
    shift_rgst_seq_if.slave bus
);
    typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

    localparam logic [1:0] ModeLogic  = 2'b00;
    localparam logic [1:0] ModeArith  = 2'b01;
    localparam logic [1:0] ModeRotate = 2'b10;
    localparam logic [1:0] ModeSerial = 2'b11;

    state_e             state_q;
    logic [WIDTH-1:0]   data_q;
    logic               shift_out_q;
    logic               busy_q;
    logic               done_q;
    logic [SHAMT_W-1:0] cnt_q;
    logic               dir_q;
    logic [1:0]         mode_q;
`ifdef RGST_STICKY_EN
    logic               sticky_q;
`endif

    logic [WIDTH-1:0]   step_data;
    logic               step_out;
    logic               fill;

    // Result of a single step from the current register contents.
    always_comb begin
        fill      = 1'b0;
        step_out  = 1'b0;
        step_data = data_q;
        if (!dir_q) begin
            step_out = data_q[WIDTH-1];
            unique case (mode_q)
                ModeLogic:  fill = 1'b0;
                ModeArith:  fill = 1'b0;
                ModeRotate: fill = data_q[WIDTH-1];
                ModeSerial: fill = bus.serial_in;
                default:    fill = 1'b0;
            endcase
            step_data = {data_q[WIDTH-2:0], fill};
        end else begin
            step_out = data_q[0];
            unique case (mode_q)
                ModeLogic:  fill = 1'b0;
                ModeArith:  fill = data_q[WIDTH-1];
                ModeRotate: fill = data_q[0];
                ModeSerial: fill = bus.serial_in;
                default:    fill = 1'b0;
            endcase
            step_data = {fill, data_q[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            state_q     <= StIdle;
            data_q      <= '0;
            shift_out_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            cnt_q       <= '0;
            dir_q       <= 1'b0;
            mode_q      <= ModeLogic;
`ifdef RGST_STICKY_EN
            sticky_q    <= 1'b0;
`endif
        end else begin
            unique case (state_q)
                StIdle: begin
                    done_q <= 1'b0;
                    busy_q <= 1'b0;
                    if (bus.load_enable) begin
                        data_q   <= bus.data_in;
`ifdef RGST_STICKY_EN
                        sticky_q <= 1'b0;
`endif
                    end else if (bus.start) begin
                        busy_q   <= 1'b1;
`ifdef RGST_STICKY_EN
                        sticky_q <= 1'b0;
`endif
                        if (bus.shamt != '0) begin
                            dir_q   <= bus.dir;
                            mode_q  <= bus.mode;
                            cnt_q   <= bus.shamt;
                            state_q <= StShift;
                        end else begin
                            done_q  <= 1'b1;
                            state_q <= StDone;
                        end
                    end
                end
                StShift: begin
                    data_q      <= step_data;
                    shift_out_q <= step_out;
`ifdef RGST_STICKY_EN
                    sticky_q    <= sticky_q | step_out;
`endif
                    cnt_q       <= cnt_q - SHAMT_W'(1);
                    if (cnt_q == SHAMT_W'(1)) begin
                        done_q  <= 1'b1;
                        state_q <= StDone;
                    end
                end
                StDone: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end
                default: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign bus.data_out  = data_q;
    assign bus.shift_out = shift_out_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
`ifdef RGST_STICKY_EN
    assign bus.sticky    = sticky_q;
`endif

endmodule

// File: tb/tb_shift_rgst_seq.sv
// Directed, table-driven bench for shift_rgst_seq (WIDTH=8, SHAMT_W=4).
module tb_shift_rgst_seq;
    localparam int unsigned WIDTH   = 8;
    localparam int unsigned SHAMT_W = 4;

    logic clk = 1'b0;
    logic reset_n;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    shift_rgst_seq_if #(.WIDTH(WIDTH), .SHAMT_W(SHAMT_W)) bus ();

    shift_rgst_seq #(.WIDTH(WIDTH), .SHAMT_W(SHAMT_W)) dut (
        .clk_i   (clk),
        .reset_ni(reset_n),
        .bus     (bus.slave)
    );

    typedef struct {
        logic        do_load;
        logic [7:0]  ld;
        logic        dir;
        logic [1:0]  mode;
        logic [3:0]  shamt;
        logic [15:0] pat;
        logic [7:0]  exp_data;
        logic        exp_so;
        logic        exp_sticky;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int n;
        if (v.do_load) begin
            bus.load_enable = 1'b1;
            bus.data_in     = v.ld;
            tick();
            bus.load_enable = 1'b0;
            chk($sformatf("v%0d load data", idx), 32'(bus.data_out), 32'(v.ld));
        end
        bus.dir   = v.dir;
        bus.mode  = v.mode;
        bus.shamt = v.shamt;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        bus.dir   = ~v.dir;
        bus.mode  = ~v.mode;
        n = 0;
        while (!bus.done && n < 40) begin
            chk($sformatf("v%0d busy step%0d", idx, n), 32'(bus.busy), 32'd1);
            bus.serial_in = v.pat[n % 16];
            tick();
            n++;
        end
        chk($sformatf("v%0d done seen", idx), 32'(bus.done), 32'd1);
        chk($sformatf("v%0d latency", idx), 32'(n), 32'(v.shamt));
        chk($sformatf("v%0d busy in done", idx), 32'(bus.busy), 32'd1);
        chk($sformatf("v%0d data", idx), 32'(bus.data_out), 32'(v.exp_data));
        chk($sformatf("v%0d shift_out", idx), 32'(bus.shift_out), 32'(v.exp_so));
`ifdef RGST_STICKY_EN
        chk($sformatf("v%0d sticky", idx), 32'(bus.sticky), 32'(v.exp_sticky));
`endif
        tick();
        chk($sformatf("v%0d done pulse", idx), 32'(bus.done), 32'd0);
        chk($sformatf("v%0d busy drop", idx), 32'(bus.busy), 32'd0);
    endtask

    initial begin
        int n;
        logic seen_done;
        //          load  ld     dir   mode   sh     pat       data   so    sticky
        vecs[0] = '{1'b1, 8'hB4, 1'b0, 2'b00, 4'd3,  16'h0000, 8'hA0, 1'b1, 1'b1};
        vecs[1] = '{1'b1, 8'hB4, 1'b1, 2'b01, 4'd2,  16'h0000, 8'hED, 1'b0, 1'b0};
        vecs[2] = '{1'b1, 8'h81, 1'b1, 2'b10, 4'd9,  16'h0000, 8'hC0, 1'b1, 1'b1};
        vecs[3] = '{1'b1, 8'h00, 1'b0, 2'b11, 4'd4,  16'h000D, 8'h0B, 1'b0, 1'b0};
        vecs[4] = '{1'b0, 8'h00, 1'b0, 2'b00, 4'd0,  16'h0000, 8'h0B, 1'b0, 1'b0};
        vecs[5] = '{1'b1, 8'h80, 1'b1, 2'b01, 4'd12, 16'h0000, 8'hFF, 1'b1, 1'b1};
        vecs[6] = '{1'b1, 8'hFF, 1'b0, 2'b00, 4'd15, 16'h0000, 8'h00, 1'b0, 1'b1};
        vecs[7] = '{1'b1, 8'h05, 1'b1, 2'b00, 4'd3,  16'h0000, 8'h00, 1'b1, 1'b1};

        bus.load_enable = 1'b0;
        bus.data_in     = '0;
        bus.start       = 1'b0;
        bus.dir         = 1'b0;
        bus.mode        = 2'b00;
        bus.serial_in   = 1'b0;
        bus.shamt       = '0;
        reset_n         = 1'b0;
        tick();
        tick();
        chk("reset data", 32'(bus.data_out), 32'h0);
        chk("reset shift_out", 32'(bus.shift_out), 32'h0);
        chk("reset busy", 32'(bus.busy), 32'h0);
        chk("reset done", 32'(bus.done), 32'h0);
`ifdef RGST_STICKY_EN
        chk("reset sticky", 32'(bus.sticky), 32'h0);
`endif
        reset_n = 1'b1;
        tick();

        for (int i = 0; i < 8; i++) run_vec(i, vecs[i]);

        // Sticky stays clear when only zeros leave the register.
        run_vec(8, '{1'b1, 8'h08, 1'b1, 2'b00, 4'd3, 16'h0000, 8'h01, 1'b0, 1'b0});

        // Load and start together: load wins, start dropped.
        bus.load_enable = 1'b1;
        bus.data_in     = 8'h5A;
        bus.start       = 1'b1;
        bus.shamt       = 4'd2;
        tick();
        bus.load_enable = 1'b0;
        bus.start       = 1'b0;
        chk("load+start data", 32'(bus.data_out), 32'h5A);
        chk("load+start busy", 32'(bus.busy), 32'h0);
        tick();
        chk("load+start idle", 32'(bus.busy), 32'h0);

        // Load during SHIFT is ignored.
        bus.load_enable = 1'b1;
        bus.data_in     = 8'hFF;
        tick();
        bus.load_enable = 1'b0;
        bus.dir   = 1'b1;
        bus.mode  = 2'b00;
        bus.shamt = 4'd6;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        bus.load_enable = 1'b1;
        bus.data_in     = 8'h12;
        tick();
        bus.load_enable = 1'b0;
        n = 2;
        while (!bus.done && n < 40) begin
            tick();
            n++;
        end
        chk("ignore load done", 32'(bus.done), 32'd1);
        chk("ignore load latency", 32'(n), 32'd6);
        chk("ignore load data", 32'(bus.data_out), 32'h03);
        tick();

        // Reset mid-operation abandons the shift without a done pulse.
        bus.load_enable = 1'b1;
        bus.data_in     = 8'hFF;
        tick();
        bus.load_enable = 1'b0;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        tick();
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        chk("midreset data", 32'(bus.data_out), 32'h0);
        chk("midreset busy", 32'(bus.busy), 32'h0);
        chk("midreset done", 32'(bus.done), 32'h0);
        chk("midreset shift_out", 32'(bus.shift_out), 32'h0);
        seen_done = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (bus.done || bus.busy) seen_done = 1'b1;
        end
        chk("midreset no done", 32'(seen_done), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
